lfsr_sync_checker: RTL

- Receive end of the 8-bit serial LFSR link. Consumes the single-bit stream `q` from the `lfsr` generator.
- Self-synchronises by seeding its own register from received bits, then predicts each next bit.
- Declares lock, flywheels while locked, counts bit errors, and drops lock on excessive errors.
- Sits beside the generator as the PRBS/link-integrity checker.

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/lfsr_window_mon.sv | 72 +++++++
 rtl/lfsr_sync_checker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit serial LFSR link.
// Used by the generator and by the receive-side checker.
package lfsr_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 8'b1011_1000;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lfsr_state_e;

endpackage

// File: rtl/lfsr_window_mon.sv
// Loss-of-lock window monitor and saturating error counter
// for the LFSR sync checker.
module lfsr_window_mon #(
   parameter int WIN_LEN   = 64,
   parameter int ERR_LIMIT = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             err,
   input  logic             clear_cnt,
   input  logic             arm,
   output logic             drop_lock,
   output logic [CNT_W-1:0] err_count
);

   localparam int WB_W = $clog2(WIN_LEN + 1);
   localparam int WE_W = $clog2(ERR_LIMIT + 1);
   localparam logic [WB_W-1:0] WB_LAST = WB_W'(WIN_LEN - 1);
   localparam logic [WE_W-1:0] WE_MAX  = WE_W'(ERR_LIMIT);

   logic [WB_W-1:0]  win_bits_q, win_bits_d;
   logic [WE_W-1:0]  win_errs_q, win_errs_d;
   logic [WE_W-1:0]  errs_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit;

   assign hit = tick && err;

   always_comb begin
      errs_inc = win_errs_q;
      if (hit && win_errs_q != WE_MAX) begin
         errs_inc = win_errs_q + WE_W'(1);
      end
      drop_lock  = hit && (errs_inc == WE_MAX);
      win_bits_d = win_bits_q;
      win_errs_d = win_errs_q;
      if (arm) begin
         win_bits_d = '0;
         win_errs_d = '0;
      end else if (tick) begin
         // The last bit of a window is counted, then the window restarts
         if (win_bits_q == WB_LAST) begin
            win_bits_d = '0;
            win_errs_d = '0;
         end else begin
            win_bits_d = win_bits_q + WB_W'(1);
            win_errs_d = errs_inc;
         end
      end
      cnt_d = clear_cnt ? '0 : cnt_q;
      if (hit && cnt_d != '1) begin
         cnt_d = cnt_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_bits_q <= '0;
         win_errs_q <= '0;
         cnt_q      <= '0;
      end else begin
         win_bits_q <= win_bits_d;
         win_errs_q <= win_errs_d;
         cnt_q      <= cnt_d;
      end
   end

   assign err_count = cnt_q;

endmodule

// File: rtl/lfsr_sync_checker.sv
// Self-synchronising PRBS checker for the 8-bit serial LFSR link:
// hunts, verifies, locks and flywheels on the received stream.
module lfsr_sync_checker
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS,
   parameter int LOCK_CNT  = 16,
   parameter int WIN_LEN   = 64,
   parameter int ERR_LIMIT = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_bit,
   input  logic              in_valid,
   input  logic              clear_cnt,
   output logic              locked,
   output logic              bit_err,
   output logic [CNT_W-1:0]  err_count,
   output logic [LFSR_W-1:0] hist
);

   lfsr_state_e       state_q, state_d;
   logic [LFSR_W-1:0] s_q, s_d, s_shift;
   logic [2:0]        fill_q, fill_d;
   logic [7:0]        consec_q, consec_d, consec_inc;
   logic              locked_q, bit_err_q;
   logic              pred, mis, tick, arm, drop_lock;

   assign pred       = ^(s_q & TAPS);
   assign mis        = in_bit ^ pred;
   assign tick       = in_valid && (state_q == LOCKED);
   assign s_shift    = {s_q[LFSR_W-2:0], in_bit};
   assign consec_inc = consec_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      fill_d   = fill_q;
      consec_d = consec_q;
      arm      = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               s_d    = s_shift;
               fill_d = fill_q + 3'd1;
               if (fill_q == 3'd7) begin
                  fill_d   = 3'd0;
                  consec_d = 8'd0;
                  if (s_shift != '0) state_d = CHECK;
               end
            end
            CHECK: begin
               s_d = s_shift;
               if (s_shift == '0) begin
                  state_d  = HUNT;
                  fill_d   = 3'd0;
                  consec_d = 8'd0;
               end else if (mis) begin
                  consec_d = 8'd0;
               end else begin
                  consec_d = consec_inc;
                  if (consec_inc == 8'(LOCK_CNT)) begin
                     state_d = LOCKED;
                     arm     = 1'b1;
                  end
               end
            end
            LOCKED: begin
               // Flywheel on the prediction so line errors never enter S
               s_d = {s_q[LFSR_W-2:0], pred};
               if (drop_lock) begin
                  state_d  = HUNT;
                  fill_d   = 3'd0;
                  consec_d = 8'd0;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= HUNT;
         s_q       <= '0;
         fill_q    <= 3'd0;
         consec_q  <= 8'd0;
         locked_q  <= 1'b0;
         bit_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         fill_q    <= fill_d;
         consec_q  <= consec_d;
         locked_q  <= (state_d == LOCKED);
         bit_err_q <= tick && mis;
      end
   end

   lfsr_window_mon #(
      .WIN_LEN  (WIN_LEN),
      .ERR_LIMIT(ERR_LIMIT),
      .CNT_W    (CNT_W)
   ) u_win (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .err      (mis),
      .clear_cnt(clear_cnt),
      .arm      (arm),
      .drop_lock(drop_lock),
      .err_count(err_count)
   );

   assign locked  = locked_q;
   assign bit_err = bit_err_q;
   assign hist    = s_q;

endmodule
